// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC vectoring engine.
// Angles are Q2.13 radians; GAIN_INV is 1/K in Q0.15.
package cordic_pkg;

  localparam int PI         = 25736;
  localparam int HALF_PI    = 12868;
  localparam logic [15:0] GAIN_INV = 16'h4DBA;
  localparam int ROUND_HALF = 16384;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ROT  = 3'd2,
    ST_COMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // atan(2^-idx) in Q2.13
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd6434;
      4'd1:    atan_lut = 16'd3798;
      4'd2:    atan_lut = 16'd2007;
      4'd3:    atan_lut = 16'd1019;
      4'd4:    atan_lut = 16'd511;
      4'd5:    atan_lut = 16'd256;
      4'd6:    atan_lut = 16'd128;
      4'd7:    atan_lut = 16'd64;
      4'd8:    atan_lut = 16'd32;
      4'd9:    atan_lut = 16'd16;
      4'd10:   atan_lut = 16'd8;
      4'd11:   atan_lut = 16'd4;
      4'd12:   atan_lut = 16'd2;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_atan2_mag_if.sv
// Operand/result handshake bundle for cordic_atan2_mag.
// master drives operands and out_ready; slave is the CORDIC engine.
interface cordic_atan2_mag_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  in_x;
  logic signed [DATA_WIDTH-1:0]  in_y;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [PHASE_WIDTH-1:0] out_phase;
  logic [DATA_WIDTH:0]           out_mag;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_phase, out_mag
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_phase, out_mag
  );
endinterface

// File: rtl/cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y toward zero
// and accumulates the rotated angle in z.
module cordic_vec_step
  import cordic_pkg::*;
#(
  parameter int W  = 18,
  parameter int ZW = 17
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [ZW-1:0] z,
  input  logic [3:0]           shift,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [W-1:0]  xs;
  logic signed [W-1:0]  ys;
  logic signed [ZW-1:0] da;

  // rotate against the sign of y
  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    da = ZW'(atan_lut(shift));
    if (!y[W-1]) begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + da;
    end else begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - da;
    end
  end

endmodule

// File: rtl/cordic_atan2_mag.sv
// Iterative CORDIC vectoring engine: phase = atan2(y,x) in Q2.13, magnitude in Q2.14.
// Define CORDIC_GAIN_COMP_EN to remove the CORDIC gain from out_mag (adds one cycle).
module cordic_atan2_mag
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER        = 14
) (
  input logic               clk,
  input logic               rst,
  cordic_atan2_mag_if.slave bus
);

  localparam int W   = DATA_WIDTH + 2;
  localparam int ZW  = PHASE_WIDTH + 1;
  localparam logic signed [ZW-1:0] PI_Z   = ZW'(PI);
  localparam logic signed [ZW-1:0] HPI_Z  = ZW'(HALF_PI);
  localparam logic [3:0]           LAST_I = 4'(ITER - 1);

  state_t                    state_r;
  state_t                    state_nx;
  logic signed [W-1:0]       x_r;
  logic signed [W-1:0]       y_r;
  logic signed [ZW-1:0]      z_r;
  logic [3:0]                iter_r;
  logic                      zero_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic signed [PHASE_WIDTH-1:0] out_phase_r;
  logic [DATA_WIDTH:0]       out_mag_r;

  logic signed [W-1:0]       step_x;
  logic signed [W-1:0]       step_y;
  logic signed [ZW-1:0]      step_z;
  logic signed [PHASE_WIDTH-1:0] phase_sat;
  logic [DATA_WIDTH:0]       mag_src;

  cordic_vec_step #(.W(W), .ZW(ZW)) u_step (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .shift  (iter_r),
    .x_next (step_x),
    .y_next (step_y),
    .z_next (step_z)
  );

  // next-state decode
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) state_nx = ST_PRE;
        else              state_nx = ST_IDLE;
      end
      ST_PRE:  state_nx = ST_ROT;
      ST_ROT: begin
        if (iter_r == LAST_I) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nx = ST_COMP;
`else
          state_nx = ST_DONE;
`endif
        end else begin
          state_nx = ST_ROT;
        end
      end
      ST_COMP: state_nx = ST_DONE;
      ST_DONE: begin
        if (out_valid_r && bus.out_ready) state_nx = ST_IDLE;
        else                              state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // the zero vector has no defined angle; force 0 instead of the accumulated table sum
  always_comb begin
    phase_sat = z_r[PHASE_WIDTH-1:0];
    if (zero_r)              phase_sat = '0;
    else if (z_r > PI_Z)     phase_sat = PHASE_WIDTH'(PI);
    else if (z_r < -PI_Z)    phase_sat = -PHASE_WIDTH'(PI);
    else                     phase_sat = z_r[PHASE_WIDTH-1:0];
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PRW = DATA_WIDTH + 16;
  logic [DATA_WIDTH:0] comp_r;
  logic [PRW-1:0]      prod_s;

  // raw magnitude times 1/K, rounded half-up
  always_comb begin
    prod_s  = PRW'(x_r[DATA_WIDTH:0]) * PRW'(GAIN_INV) + PRW'(ROUND_HALF);
    mag_src = comp_r;
  end

  // gain-compensated magnitude register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    comp_r <= '0;
    else if (state_r == ST_COMP) comp_r <= prod_s[PRW-1:15];
    else                        comp_r <= comp_r;
  end
`else
  // x is non-negative after the fold, so its low bits are the raw magnitude
  always_comb begin
    mag_src = x_r[DATA_WIDTH:0];
  end
`endif

  // state, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      iter_r      <= 4'd0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_phase_r <= '0;
      out_mag_r   <= '0;
    end else begin
      state_r    <= state_nx;
      in_ready_r <= (state_nx == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_r    <= {{2{bus.in_x[DATA_WIDTH-1]}}, bus.in_x};
            y_r    <= {{2{bus.in_y[DATA_WIDTH-1]}}, bus.in_y};
            z_r    <= '0;
            iter_r <= 4'd0;
            zero_r <= (bus.in_x == '0) && (bus.in_y == '0);
          end
        end
        ST_PRE: begin
          // y>=0 folds to +pi/2 so the negative real axis resolves to +pi
          if (x_r[W-1]) begin
            if (!y_r[W-1]) begin
              x_r <= y_r;
              y_r <= -x_r;
              z_r <= HPI_Z;
            end else begin
              x_r <= -y_r;
              y_r <= x_r;
              z_r <= -HPI_Z;
            end
          end
        end
        ST_ROT: begin
          x_r    <= step_x;
          y_r    <= step_y;
          z_r    <= step_z;
          iter_r <= iter_r + 4'd1;
        end
        ST_DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_phase_r <= phase_sat;
            out_mag_r   <= mag_src;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_phase = out_phase_r;
  assign bus.out_mag   = out_mag_r;

endmodule
